// File: rtl/video_hsmooth_pkg.sv
// Shared definitions for the horizontal [1 2 1]/4 video smoothing stage:
// default geometry, packet-type code, FSM states and RGB field positions.
package video_pkg;

  localparam int          IMAGE_W_DEF        = 640;
  localparam logic [3:0]  PKT_TYPE_VIDEO_DEF = 4'h0;

  localparam int PIX_W = 24;
  localparam int CH_W  = 8;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  typedef logic [PIX_W-1:0] pixel_t;

  // HDR waits for a header, PASS forwards control packets, FIRST/MID walk a
  // video line, FLUSH emits the right-edge pixel without accepting input.
  typedef enum logic [2:0] {
    HDR   = 3'd0,
    PASS  = 3'd1,
    FIRST = 3'd2,
    MID   = 3'd3,
    FLUSH = 3'd4
  } state_t;

endpackage

// File: rtl/video_hsmooth_if.sv
// Avalon-ST style streaming bundle: data with valid/ready handshake and
// sop/eop packet framing.
interface video_hsmooth_if;
  import video_pkg::*;

  pixel_t data;
  logic   valid;
  logic   ready;
  logic   sop;
  logic   eop;

  modport master (output data, output valid, output sop, output eop, input  ready);
  modport slave  (input  data, input  valid, input  sop, input  eop, output ready);

endinterface

// File: rtl/video_hsmooth_px121.sv
// Combinational 3-tap [1 2 1]/4 filter with rounding, applied per RGB
// channel. With en_i low the centre tap passes through untouched.
module hsmooth_px121
  import video_pkg::*;
(
  input  pixel_t a_i,
  input  pixel_t b_i,
  input  pixel_t c_i,
  input  logic   en_i,
  output pixel_t y_o
);

  // a + 2b + c peaks at 1020, so 10 bits hold the rounded sum exactly.
  function automatic logic [CH_W-1:0] tap121(input logic [CH_W-1:0] a,
                                             input logic [CH_W-1:0] b,
                                             input logic [CH_W-1:0] c);
    logic [CH_W+1:0] s;
    s = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c} + 10'd2;
    s = s >> 2;
    return s[CH_W-1:0];
  endfunction

  // Per-channel smoothing, or bypass of the centre tap.
  always_comb begin
    // NOTE: y_o gets a full default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    y_o = b_i;
    if (en_i) begin
      y_o[R_LSB +: CH_W] = tap121(a_i[R_LSB +: CH_W], b_i[R_LSB +: CH_W], c_i[R_LSB +: CH_W]);
      y_o[G_LSB +: CH_W] = tap121(a_i[G_LSB +: CH_W], b_i[G_LSB +: CH_W], c_i[G_LSB +: CH_W]);
      y_o[B_LSB +: CH_W] = tap121(a_i[B_LSB +: CH_W], b_i[B_LSB +: CH_W], c_i[B_LSB +: CH_W]);
    end
  end

endmodule

// File: rtl/video_hsmooth.sv
// Horizontal smoothing stage for Avalon-ST video. Video packet pixels are
// filtered [1 2 1]/4 per channel with edge replication at both line ends;
// headers and control packets pass through unchanged with one cycle latency.
module video_hsmooth
  import video_pkg::*;
#(
  parameter int         IMAGE_W        = IMAGE_W_DEF,
  parameter logic [3:0] PKT_TYPE_VIDEO = PKT_TYPE_VIDEO_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  video_hsmooth_if.slave  sink,
  video_hsmooth_if.master source
);

  localparam int X_W = $clog2(IMAGE_W + 1);

  state_t         state_q;
  logic [X_W-1:0] x_q;
  pixel_t         p0_q;
  pixel_t         p1_q;
  logic           en_q;
  logic           eop_q;

  pixel_t         src_data_q;
  logic           src_valid_q;
  logic           src_sop_q;
  logic           src_eop_q;

  logic           adv;
  logic           accept;
  logic           is_vid;
  logic           line_end;
  pixel_t         tap_c;
  pixel_t         px_d;

  // The output register may advance when it is empty or being drained.
  assign adv      = ~src_valid_q | source.ready;
  assign sink.ready = reset_n & adv & (state_q != FLUSH);
  assign accept   = sink.valid & sink.ready;
  assign is_vid   = (sink.data[3:0] == PKT_TYPE_VIDEO);
  assign line_end = (x_q == X_W'(IMAGE_W - 1)) | sink.eop;

  // The right tap replicates the last pixel while flushing a line.
  assign tap_c = (state_q == FLUSH) ? p1_q : sink.data;

  hsmooth_px121 u_px121 (
    .a_i  (p0_q),
    .b_i  (p1_q),
    .c_i  (tap_c),
    .en_i (en_q),
    .y_o  (px_d)
  );

  assign source.data  = src_data_q;
  assign source.valid = src_valid_q;
  assign source.sop   = src_sop_q;
  assign source.eop   = src_eop_q;

  // Packet FSM, line position, tap registers and registered output stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the tap registers are reset along with control state so a
      // restarted stream never filters against stale pixels.
      state_q     <= HDR;
      x_q         <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      en_q        <= 1'b0;
      eop_q       <= 1'b0;
      src_data_q  <= '0;
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
    end else if (adv) begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge register values regardless of statement order.
      src_valid_q <= 1'b0;
      if (accept && sink.sop) begin
        // Any sop is a header; a partial line in progress is dropped.
        src_valid_q <= 1'b1;
        src_data_q  <= sink.data;
        src_sop_q   <= 1'b1;
        src_eop_q   <= sink.eop;
        en_q        <= enable;
        eop_q       <= 1'b0;
        x_q         <= '0;
        if (sink.eop)   state_q <= HDR;
        else if (is_vid) state_q <= FIRST;
        else            state_q <= PASS;
      end else begin
        unique case (state_q)
          HDR: begin
            // Stray non-sop words are accepted and dropped.
          end
          PASS: begin
            if (accept) begin
              src_valid_q <= 1'b1;
              src_data_q  <= sink.data;
              src_sop_q   <= 1'b0;
              src_eop_q   <= sink.eop;
              if (sink.eop) state_q <= HDR;
            end
          end
          FIRST: begin
            if (accept) begin
              p0_q    <= sink.data;
              p1_q    <= sink.data;
              x_q     <= X_W'(1);
              eop_q   <= sink.eop;
              state_q <= sink.eop ? FLUSH : MID;
            end
          end
          MID: begin
            if (accept) begin
              src_valid_q <= 1'b1;
              src_data_q  <= px_d;
              src_sop_q   <= 1'b0;
              src_eop_q   <= 1'b0;
              p0_q        <= p1_q;
              p1_q        <= sink.data;
              x_q         <= x_q + X_W'(1);
              if (line_end) begin
                eop_q   <= sink.eop;
                state_q <= FLUSH;
              end
            end
          end
          FLUSH: begin
            src_valid_q <= 1'b1;
            src_data_q  <= px_d;
            src_sop_q   <= 1'b0;
            src_eop_q   <= eop_q;
            x_q         <= '0;
            state_q     <= eop_q ? HDR : FIRST;
          end
          default: state_q <= HDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_hsmooth.sv
// Self-checking bench for video_hsmooth: randomized packets compared against
// a packet-level reference model of the smoothing stage.
module tb_video_hsmooth;
  import video_pkg::*;

  localparam int W = 640;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [23:0] data;
  } word_t;

  typedef struct {
    word_t w;
    bit    en;
  } in_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;

  video_hsmooth_if sink_if ();
  video_hsmooth_if src_if ();

  video_hsmooth #(.IMAGE_W(W), .PKT_TYPE_VIDEO(4'h0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .sink    (sink_if),
    .source  (src_if)
  );

  always #5 clk = ~clk;

  in_t         in_q[$];
  word_t       exp_q[$];
  word_t       got_q[$];
  logic [23:0] px_buf[$];

  int          checks = 0;
  int          errors = 0;
  bit          bp_mode = 1'b0;
  bit          count_en = 1'b0;
  int          stall_cnt = 0;
  bit          hold_pend = 1'b0;
  logic [23:0] hold_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference filter: rounded weighted mean of three neighbours per channel.
  function automatic logic [23:0] smooth(input logic [23:0] a, input logic [23:0] b,
                                         input logic [23:0] c);
    logic [23:0] r;
    for (int k = 0; k < 3; k++)
      r[8*k +: 8] = 8'((int'(a[8*k +: 8]) + 2 * int'(b[8*k +: 8]) + int'(c[8*k +: 8]) + 2) / 4);
    return r;
  endfunction

  // Video packet from px_buf. An incomplete packet is cut by the next sop,
  // which discards the last pixel of a partially received line.
  task automatic add_video(input logic [23:0] hdr, input bit en, input bit complete);
    int n;
    n = px_buf.size();
    in_q.push_back('{w: '{sop: 1'b1, eop: 1'b0, data: hdr}, en: en});
    exp_q.push_back('{sop: 1'b1, eop: 1'b0, data: hdr});
    for (int i = 0; i < n; i++)
      in_q.push_back('{w: '{sop: 1'b0, eop: (complete && i == n - 1), data: px_buf[i]}, en: en});
    for (int s = 0; s < n; s += W) begin
      int  len;
      int  emit;
      bit  last;
      len  = (n - s < W) ? n - s : W;
      last = (s + len == n);
      emit = (!complete && last && len < W) ? len - 1 : len;
      for (int i = 0; i < emit; i++) begin
        logic [23:0] a, b, c, y;
        a = px_buf[s + ((i > 0) ? i - 1 : 0)];
        b = px_buf[s + i];
        c = px_buf[s + ((i + 1 < len) ? i + 1 : len - 1)];
        y = en ? smooth(a, b, c) : b;
        exp_q.push_back('{sop: 1'b0, eop: (complete && last && i == len - 1), data: y});
      end
    end
  endtask

  // Control packet from px_buf: forwarded verbatim, enable is irrelevant.
  task automatic add_ctrl(input logic [23:0] hdr);
    int n;
    n = px_buf.size();
    in_q.push_back('{w: '{sop: 1'b1, eop: 1'b0, data: hdr}, en: 1'($urandom_range(0, 1))});
    exp_q.push_back('{sop: 1'b1, eop: 1'b0, data: hdr});
    for (int i = 0; i < n; i++) begin
      in_q.push_back('{w: '{sop: 1'b0, eop: (i == n - 1), data: px_buf[i]},
                       en: 1'($urandom_range(0, 1))});
      exp_q.push_back('{sop: 1'b0, eop: (i == n - 1), data: px_buf[i]});
    end
  endtask

  // Output collection, sink stall counting and hold-while-stalled checking.
  always @(negedge clk) begin
    if (src_if.valid === 1'b1 && src_if.ready === 1'b1)
      got_q.push_back('{sop: src_if.sop, eop: src_if.eop, data: src_if.data});
    if (count_en && !sink_if.ready) stall_cnt++;
    if (reset_n && hold_pend)
      check("hold_stable", {7'd0, src_if.valid, src_if.data}, {7'd0, 1'b1, hold_data});
    hold_pend = reset_n && (src_if.valid === 1'b1) && !src_if.ready;
    hold_data = src_if.data;
  end

  // Downstream ready: always on, or a coin toss each cycle under backpressure.
  always @(posedge clk) begin
    #1;
    src_if.ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send_word(input in_t e);
    bit acc;
    int budget;
    if (bp_mode && $urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
    sink_if.data  = e.w.data;
    sink_if.sop   = e.w.sop;
    sink_if.eop   = e.w.eop;
    sink_if.valid = 1'b1;
    enable        = e.en;
    acc    = 1'b0;
    budget = 0;
    while (!acc) begin
      @(negedge clk);
      acc = sink_if.ready;
      @(posedge clk);
      #1;
      budget++;
      if (!acc && budget > 2000) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    sink_if.valid = 1'b0;
  endtask

  task automatic prep();
    in_q.delete();
    exp_q.delete();
    got_q.delete();
    px_buf.delete();
    stall_cnt = 0;
  endtask

  task automatic send_all();
    foreach (in_q[i]) send_word(in_q[i]);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (got_q.size() < exp_q.size() && b < 5000) begin
      @(posedge clk);
      b++;
    end
    if (got_q.size() < exp_q.size()) check("drain_timeout", 32'd0, 32'd1);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic compare(input string name);
    int n;
    check({name, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_w%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic run(input string name);
    count_en = 1'b1;
    send_all();
    drain();
    count_en = 1'b0;
    compare(name);
  endtask

  initial begin
    sink_if.valid = 1'b0;
    sink_if.sop   = 1'b0;
    sink_if.eop   = 1'b0;
    sink_if.data  = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_src_valid", 32'(src_if.valid), 32'd0);
    check("rst_src_data", 32'(src_if.data), 32'd0);
    check("rst_src_sop_eop", {30'd0, src_if.sop, src_if.eop}, 32'd0);
    check("rst_sink_ready", 32'(sink_if.ready), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Flat frame: two full lines of a constant colour.
    prep();
    repeat (2 * W) px_buf.push_back(24'h404040);
    add_video(24'h000000, 1'b1, 1'b1);
    run("flat");
    check("flat_stalls", stall_cnt, 2);

    // Impulse in the red channel at x=10.
    prep();
    repeat (W) px_buf.push_back(24'h000000);
    px_buf[10] = 24'hFF0000;
    add_video(24'h000000, 1'b1, 1'b1);
    run("impulse");
    if (got_q.size() > 12) begin
      check("impulse_x9", 32'(got_q[10].data), 32'h400000);
      check("impulse_x10", 32'(got_q[11].data), 32'h800000);
      check("impulse_x11", 32'(got_q[12].data), 32'h400000);
    end

    // Line edges replicate the end pixels.
    prep();
    repeat (W) px_buf.push_back(24'($urandom));
    px_buf[0]     = 24'h100000;
    px_buf[1]     = 24'h000000;
    px_buf[W - 2] = 24'h000000;
    px_buf[W - 1] = 24'h000010;
    add_video(24'hA5A5A0, 1'b1, 1'b1);
    run("edges");
    if (got_q.size() > W) begin
      check("edge_x0", 32'(got_q[1].data), 32'h0C0000);
      check("edge_x639", 32'(got_q[W].data), 32'h00000C);
    end

    // Control packet: verbatim, no stalls.
    prep();
    repeat (3) px_buf.push_back(24'($urandom));
    add_ctrl(24'h00000F);
    run("ctrl");
    check("ctrl_stalls", stall_cnt, 0);

    // Four lines under random downstream and upstream throttling.
    prep();
    repeat (4 * W) px_buf.push_back(24'($urandom));
    add_video(24'h123450, 1'b1, 1'b1);
    bp_mode = 1'b1;
    run("backpressure");
    bp_mode = 1'b0;

    // sop mid-line drops the partial line; next header is forwarded.
    prep();
    repeat (300) px_buf.push_back(24'($urandom));
    add_video(24'h000000, 1'b1, 1'b0);
    px_buf.delete();
    repeat (W) px_buf.push_back(24'($urandom));
    add_video(24'h777770, 1'b1, 1'b1);
    run("sop_midline");

    // Bypass: pixels equal the input.
    prep();
    repeat (W) px_buf.push_back(24'($urandom));
    add_video(24'h000000, 1'b0, 1'b1);
    run("bypass");

    // Short frame: second line ends early with eop.
    prep();
    repeat (W + 100) px_buf.push_back(24'($urandom));
    add_video(24'h000000, 1'b1, 1'b1);
    run("short_frame");

    // Reset after pixel x=300 has been accepted.
    prep();
    repeat (301) px_buf.push_back(24'($urandom));
    add_video(24'h000000, 1'b1, 1'b0);
    send_all();
    reset_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_src_valid", 32'(src_if.valid), 32'd0);
    check("midrst_sink_ready", 32'(sink_if.ready), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compare("pre_reset");
    prep();
    repeat (W) px_buf.push_back(24'($urandom));
    add_video(24'h000000, 1'b1, 1'b1);
    run("post_reset");

    // Random mix of packet kinds, lengths and cut-offs under throttling.
    prep();
    for (int p = 0; p < 6; p++) begin
      int n;
      px_buf.delete();
      if ($urandom_range(0, 2) == 0) begin
        n = $urandom_range(1, 5);
        repeat (n) px_buf.push_back(24'($urandom));
        add_ctrl({20'($urandom), 4'($urandom_range(1, 15))});
      end else begin
        n = $urandom_range(1, 1500);
        repeat (n) px_buf.push_back(24'($urandom));
        add_video({20'($urandom), 4'h0}, 1'($urandom_range(0, 1)),
                  (p == 5) || ($urandom_range(0, 3) != 0));
      end
    end
    bp_mode = 1'b1;
    run("mix");
    bp_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
